syncer_bus_rx_multi: RTL and testbench
======================================

# syncer_bus_rx_multi

Receive-side, multi-channel bus synchroniser.
- Accepts NUM_CH independent WIDTH-bit buses from foreign clock domains using a toggle req/ack protocol.
- Captures each bus into the local clock domain and produces per-channel valid pulses and saturating update counters.
- Adds per-channel backpressure and a selectable not-ready policy.
- Sits at the destination of CDC paths; the sender holds its bus stable while req_toggle differs from ack_toggle.

## Interface
Parameters:
- WIDTH, 8: bits per channel bus
- NUM_CH, 4: number of channels (>=1)
- SYNC_STAGES, 2: synchroniser flop depth (>=2)
- CLEAR_ON_NOT_READY, 1: 1 = busout of a channel forced to 0 while its sender is not ready; 0 = hold last value
- CNT_WIDTH, 16: update counter width

Ports:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- ready_in  in  NUM_CH  sender-out-of-reset level per channel, asynchronous
- req_toggle  in  NUM_CH  request toggle per channel, asynchronous
- busin  in  NUM_CH*WIDTH  channel c at [c*WIDTH +: WIDTH], asynchronous, quasi-static
- hold  in  NUM_CH  synchronous backpressure; 1 = do not accept a new request on that channel
- clr_cnt  in  NUM_CH  synchronous counter clear per channel
- ack_toggle  out  NUM_CH  registered acknowledge toggle returned to the sender
- busout  out  NUM_CH*WIDTH  captured bus per channel, registered
- busout_valid  out  NUM_CH  one-cycle pulse on capture
- ready_out  out  NUM_CH  synchronised ready_in
- pending  out  NUM_CH  1 = synchronised request is outstanding (sync_req != ack_toggle)
- upd_cnt  out  NUM_CH*CNT_WIDTH  per-channel capture count, saturating

## Operation
Each channel is fully independent.
- **Synchronisation:** ready_in[c] and req_toggle[c] each pass through a SYNC_STAGES flop chain; the chain outputs are rdy_s and req_s. busin is never synchronised; it is sampled only on capture.
- **Derived signals:** pending = req_s != ack_toggle; ready_out = rdy_s.
- **Not ready (rdy_s=0):**
  - ack_toggle <= req_s, so requests are drained and never left outstanding.
  - No capture, no valid pulse, counter unchanged.
  - busout <= 0 if CLEAR_ON_NOT_READY, else busout holds.
- **Ready, pending, hold=0:** capture.
  - busout <= busin slice.
  - ack_toggle <= req_s.
  - busout_valid=1 for one cycle.
  - upd_cnt increments, saturating at all-ones.
- **Ready, pending, hold=1:** stall.
  - ack_toggle, busout and upd_cnt hold; pending stays 1.
  - The sender is blocked from issuing further toggles.
- **Ready, not pending:** all state holds.
- **clr_cnt=1:** upd_cnt <= 0. This overrides a same-cycle increment, so the result is 0.
- **hold during not-ready:** ignored; the drain still happens.

## Timing
- **Reset (asynchronous, active-low):** all sync flops, ack_toggle, busout, busout_valid, ready_out, pending and upd_cnt go to 0.
- **Latency from req_toggle edge:** the capture edge, ack_toggle flip and busout_valid pulse all occur SYNC_STAGES+1 clk edges later, with hold=0 and rdy_s=1.
- **Capture rate:** at most one capture per 2 local cycles per channel.
  - pending drops in the cycle after capture.
  - The next capture needs a new toggle to pass through the synchroniser.
- **Hold release:** capture occurs on the first edge after hold returns to 0.
- **Sender reset mid-transfer:** within SYNC_STAGES+1 cycles rdy_s falls, the channel drains, and busout clears when CLEAR_ON_NOT_READY=1.
- **Sender ready rising:** ready_out rises after SYNC_STAGES edges; busout remains 0 (or holds its last value) until the first capture.
- **Simultaneous rdy_s fall and pending:** the drain wins; no valid pulse.
- **upd_cnt:** at all-ones stays at all-ones on further captures; busout_valid still pulses.

## Structure
- **Shared package syncer_pkg:**
  - SYNC_STAGES_MIN = 2.
  - Policy constants NOT_READY_CLEAR = 1 and NOT_READY_HOLD = 0.
  - A function for the saturating increment.
- **Sub-module syncer_bus_rx_ch:**
  - Contains one channel: two SYNC_STAGES synchronisers, capture register, ack register and counter.
  - The top level is a generate loop of NUM_CH instances plus bus slicing.
  - Elaboration-time checks: SYNC_STAGES>=2 and NUM_CH>=1.

## Test plan
- **Basic capture:** WIDTH=8, SYNC_STAGES=2, ready_in=1. Drive busin ch0=0xA5 and toggle req 0->1. Required: busout ch0=0xA5, busout_valid[0] pulse and ack_toggle[0]=1, all exactly 3 edges later; upd_cnt[0]=1; other channels unchanged.
- **Backpressure:** hold[1]=1, toggle req[1] with 0x3C. Required: pending[1]=1 for 20 cycles, ack and busout unchanged. Release hold; required capture of 0x3C on the next edge.
- **Not-ready clear:** busout ch2=0x77, then deassert ready_in[2]. Required: busout ch2=0 after 3 edges with CLEAR_ON_NOT_READY=1, or held at 0x77 with CLEAR_ON_NOT_READY=0. A toggle while not ready gives an ack flip but no valid pulse.
- **Saturation and clear:** CNT_WIDTH=2, 5 captures. Required: upd_cnt=3 and 5 valid pulses. clr_cnt in the same cycle as a capture gives upd_cnt=0.
- **Reset mid-operation:** assert reset while pending=1 on all channels. Required: all outputs 0 immediately. After release, a new toggle is captured with normal latency.
- **Random concurrent toggles on all channels with random hold:** scoreboard requires every accepted toggle yields exactly one valid pulse with the matching data, and no lost or duplicated captures.

Source files
------------

// File: rtl/syncer_pkg.sv
// Shared constants and helpers for the multi-channel toggle-handshake bus receiver.
// Imported by the per-channel receiver and by the top-level wrapper.
package syncer_pkg;

    localparam int SYNC_STAGES_MIN = 2;

    // Behaviour of a channel's busout while its sender is not ready
    localparam bit NOT_READY_CLEAR = 1'b1;
    localparam bit NOT_READY_HOLD  = 1'b0;

    // What a channel does on the next edge, decoded from the synchronised inputs
    typedef enum logic [1:0] {
        CH_DRAIN   = 2'd0,
        CH_IDLE    = 2'd1,
        CH_STALL   = 2'd2,
        CH_CAPTURE = 2'd3
    } ch_action_e;

    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? max_val : value + 64'd1;
    endfunction

endpackage

// File: rtl/syncer_bus_rx_ch.sv
// One receive channel: ready/request synchronisers, capture register,
// acknowledge toggle and saturating capture counter.
module syncer_bus_rx_ch
    import syncer_pkg::*;
#(
    parameter int WIDTH              = 8,
    parameter int SYNC_STAGES        = 2,
    parameter bit CLEAR_ON_NOT_READY = 1'b1,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ready_in,
    input  logic                 req_toggle,
    input  logic [WIDTH-1:0]     busin,
    input  logic                 hold,
    input  logic                 clr_cnt,
    output logic                 ack_toggle,
    output logic [WIDTH-1:0]     busout,
    output logic                 busout_valid,
    output logic                 ready_out,
    output logic                 pending,
    output logic [CNT_WIDTH-1:0] upd_cnt
);

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync_stages
        $error("syncer_bus_rx_ch: SYNC_STAGES must be at least %0d", SYNC_STAGES_MIN);
    end

    logic [SYNC_STAGES-1:0] rdy_sync_reg;
    logic [SYNC_STAGES-1:0] req_sync_reg;
    logic                   rdy_s;
    logic                   req_s;

    logic                   ack_reg;
    logic                   ack_next;
    logic [WIDTH-1:0]       busout_reg;
    logic [WIDTH-1:0]       busout_next;
    logic                   valid_reg;
    logic                   valid_next;
    logic [CNT_WIDTH-1:0]   cnt_reg;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic                   pending_s;
    ch_action_e             action;

    // busin is deliberately not synchronised: the sender keeps it stable
    // until the acknowledge comes back, so it is only sampled on capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_sync_reg <= '0;
            req_sync_reg <= '0;
        end else begin
            rdy_sync_reg <= {rdy_sync_reg[SYNC_STAGES-2:0], ready_in};
            req_sync_reg <= {req_sync_reg[SYNC_STAGES-2:0], req_toggle};
        end
    end

    assign rdy_s     = rdy_sync_reg[SYNC_STAGES-1];
    assign req_s     = req_sync_reg[SYNC_STAGES-1];
    assign pending_s = (req_s != ack_reg);

    always_comb begin
        action = CH_IDLE;
        if (!rdy_s) begin
            action = CH_DRAIN;
        end else if (pending_s) begin
            action = hold ? CH_STALL : CH_CAPTURE;
        end
    end

    always_comb begin
        ack_next    = ack_reg;
        busout_next = busout_reg;
        valid_next  = 1'b0;
        cnt_next    = cnt_reg;
        case (action)
            CH_DRAIN: begin
                // Sender is in reset: keep the handshake balanced so nothing is left outstanding
                ack_next = req_s;
                if (CLEAR_ON_NOT_READY == NOT_READY_CLEAR) begin
                    busout_next = '0;
                end
            end
            CH_CAPTURE: begin
                ack_next    = req_s;
                busout_next = busin;
                valid_next  = 1'b1;
                cnt_next    = CNT_WIDTH'(sat_inc(64'(cnt_reg), CNT_WIDTH));
            end
            default: begin
            end
        endcase
        if (clr_cnt) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_reg    <= 1'b0;
            busout_reg <= '0;
            valid_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            ack_reg    <= ack_next;
            busout_reg <= busout_next;
            valid_reg  <= valid_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign ack_toggle   = ack_reg;
    assign busout       = busout_reg;
    assign busout_valid = valid_reg;
    assign ready_out    = rdy_s;
    assign pending      = pending_s;
    assign upd_cnt      = cnt_reg;

endmodule

// File: rtl/syncer_bus_rx_multi.sv
// Receive side of NUM_CH independent toggle-handshake CDC buses; each channel
// is an instance of syncer_bus_rx_ch working on its own slice of the flat buses.
module syncer_bus_rx_multi
    import syncer_pkg::*;
#(
    parameter int WIDTH              = 8,
    parameter int NUM_CH             = 4,
    parameter int SYNC_STAGES        = 2,
    parameter bit CLEAR_ON_NOT_READY = 1'b1,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           ready_in,
    input  logic [NUM_CH-1:0]           req_toggle,
    input  logic [NUM_CH*WIDTH-1:0]     busin,
    input  logic [NUM_CH-1:0]           hold,
    input  logic [NUM_CH-1:0]           clr_cnt,
    output logic [NUM_CH-1:0]           ack_toggle,
    output logic [NUM_CH*WIDTH-1:0]     busout,
    output logic [NUM_CH-1:0]           busout_valid,
    output logic [NUM_CH-1:0]           ready_out,
    output logic [NUM_CH-1:0]           pending,
    output logic [NUM_CH*CNT_WIDTH-1:0] upd_cnt
);

    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("syncer_bus_rx_multi: NUM_CH must be at least 1");
    end

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync_stages
        $error("syncer_bus_rx_multi: SYNC_STAGES must be at least %0d", SYNC_STAGES_MIN);
    end

    genvar gi;
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
        syncer_bus_rx_ch #(
            .WIDTH              (WIDTH),
            .SYNC_STAGES        (SYNC_STAGES),
            .CLEAR_ON_NOT_READY (CLEAR_ON_NOT_READY),
            .CNT_WIDTH          (CNT_WIDTH)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .ready_in     (ready_in[gi]),
            .req_toggle   (req_toggle[gi]),
            .busin        (busin[gi*WIDTH +: WIDTH]),
            .hold         (hold[gi]),
            .clr_cnt      (clr_cnt[gi]),
            .ack_toggle   (ack_toggle[gi]),
            .busout       (busout[gi*WIDTH +: WIDTH]),
            .busout_valid (busout_valid[gi]),
            .ready_out    (ready_out[gi]),
            .pending      (pending[gi]),
            .upd_cnt      (upd_cnt[gi*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_syncer_bus_rx_multi.sv
// Directed and randomised checks of syncer_bus_rx_multi against a
// transaction-level model (expected data queues and saturating counts).
module tb_syncer_bus_rx_multi;

    localparam int WIDTH       = 8;
    localparam int NUM_CH      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_WIDTH   = 2;
    localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;
    localparam int RND_PER_CH  = 15;

    logic                        clk;
    logic                        reset;
    logic [NUM_CH-1:0]           ready_in;
    logic [NUM_CH-1:0]           req_toggle;
    logic [NUM_CH*WIDTH-1:0]     busin;
    logic [NUM_CH-1:0]           hold;
    logic [NUM_CH-1:0]           clr_cnt;
    logic [NUM_CH-1:0]           ack_toggle;
    logic [NUM_CH*WIDTH-1:0]     busout;
    logic [NUM_CH-1:0]           busout_valid;
    logic [NUM_CH-1:0]           ready_out;
    logic [NUM_CH-1:0]           pending;
    logic [NUM_CH*CNT_WIDTH-1:0] upd_cnt;

    int tests;
    int fails;

    syncer_bus_rx_multi #(
        .WIDTH              (WIDTH),
        .NUM_CH             (NUM_CH),
        .SYNC_STAGES        (SYNC_STAGES),
        .CLEAR_ON_NOT_READY (1'b1),
        .CNT_WIDTH          (CNT_WIDTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ready_in     (ready_in),
        .req_toggle   (req_toggle),
        .busin        (busin),
        .hold         (hold),
        .clr_cnt      (clr_cnt),
        .ack_toggle   (ack_toggle),
        .busout       (busout),
        .busout_valid (busout_valid),
        .ready_out    (ready_out),
        .pending      (pending),
        .upd_cnt      (upd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [63:0] bo(input int c);
        return 64'(busout[c*WIDTH +: WIDTH]);
    endfunction

    function automatic logic [63:0] cnt(input int c);
        return 64'(upd_cnt[c*CNT_WIDTH +: CNT_WIDTH]);
    endfunction

    task automatic set_bus(input int c, input logic [WIDTH-1:0] d);
        busin[c*WIDTH +: WIDTH] = d;
    endtask

    // Scoreboard state for the random phase
    logic [WIDTH-1:0] exp_q [NUM_CH][$];
    int               cnt_m [NUM_CH];
    int               sent  [NUM_CH];
    int               got   [NUM_CH];

    initial begin
        int pulses;
        logic [WIDTH-1:0] d;

        tests = 0;
        fails = 0;
        reset      = 1'b0;
        ready_in   = '0;
        req_toggle = '0;
        hold       = '0;
        clr_cnt    = '0;
        busin      = '0;

        // Reset state
        step(3);
        check("rst_busout",  64'(busout),       64'h0);
        check("rst_ack",     64'(ack_toggle),   64'h0);
        check("rst_valid",   64'(busout_valid), 64'h0);
        check("rst_ready",   64'(ready_out),    64'h0);
        check("rst_pending", 64'(pending),      64'h0);
        check("rst_cnt",     64'(upd_cnt),      64'h0);

        reset    = 1'b1;
        ready_in = '1;
        step(1);
        check("ready_lat1", 64'(ready_out), 64'h0);
        step(1);
        check("ready_up", 64'(ready_out), 64'hF);

        // Basic capture on channel 0
        set_bus(0, 8'hA5);
        req_toggle[0] = 1'b1;
        step(1);
        check("basic_valid_e1", 64'(busout_valid), 64'h0);
        step(1);
        check("basic_valid_e2", 64'(busout_valid), 64'h0);
        check("basic_pending", 64'(pending[0]), 64'h1);
        step(1);
        check("basic_data", bo(0), 64'hA5);
        check("basic_valid", 64'(busout_valid), 64'h1);
        check("basic_ack", 64'(ack_toggle), 64'h1);
        check("basic_cnt", cnt(0), 64'd1);
        check("basic_others", 64'(busout[NUM_CH*WIDTH-1:WIDTH]), 64'h0);
        $display("[TB] ch0 capture data=%02h", busout[7:0]);
        step(1);
        check("basic_valid_drop", 64'(busout_valid[0]), 64'h0);
        check("basic_pending_drop", 64'(pending[0]), 64'h0);

        // Backpressure on channel 1
        hold[1] = 1'b1;
        set_bus(1, 8'h3C);
        req_toggle[1] = 1'b1;
        step(2);
        for (int i = 0; i < 20; i++) begin
            check("bp_pending", 64'(pending[1]), 64'h1);
            check("bp_ack", 64'(ack_toggle[1]), 64'h0);
            check("bp_busout", bo(1), 64'h0);
            check("bp_valid", 64'(busout_valid[1]), 64'h0);
            step(1);
        end
        hold[1] = 1'b0;
        step(1);
        check("bp_release_data", bo(1), 64'h3C);
        check("bp_release_valid", 64'(busout_valid[1]), 64'h1);
        check("bp_release_ack", 64'(ack_toggle[1]), 64'h1);
        check("bp_release_cnt", cnt(1), 64'd1);
        $display("[TB] ch1 capture data=%02h after hold release", busout[15:8]);
        step(1);

        // Not-ready clear on channel 2
        set_bus(2, 8'h77);
        req_toggle[2] = 1'b1;
        step(3);
        check("nr_capture", bo(2), 64'h77);
        check("nr_capture_valid", 64'(busout_valid[2]), 64'h1);
        $display("[TB] ch2 capture data=%02h", busout[23:16]);
        step(1);
        ready_in[2] = 1'b0;
        step(2);
        check("nr_ready_low", 64'(ready_out[2]), 64'h0);
        check("nr_busout_pre", bo(2), 64'h77);
        step(1);
        check("nr_busout_clear", bo(2), 64'h0);
        check("nr_ack_hold", 64'(ack_toggle[2]), 64'h1);
        set_bus(2, 8'h11);
        req_toggle[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("nr_no_valid", 64'(busout_valid[2]), 64'h0);
        end
        check("nr_drain_ack", 64'(ack_toggle[2]), 64'h0);
        check("nr_drain_cnt", cnt(2), 64'd1);
        check("nr_drain_busout", bo(2), 64'h0);
        $display("[TB] ch2 toggle drained while not ready");
        ready_in[2] = 1'b1;
        step(2);
        check("nr_ready_back", 64'(ready_out[2]), 64'h1);
        check("nr_ready_back_pending", 64'(pending[2]), 64'h0);
        check("nr_ready_back_busout", bo(2), 64'h0);

        // Counter saturation and clear on channel 3
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            set_bus(3, 8'(8'hC0 + i));
            req_toggle[3] = ~req_toggle[3];
            step(2);
            check("sat_early_valid", 64'(busout_valid[3]), 64'h0);
            step(1);
            if (busout_valid[3]) pulses++;
            check("sat_data", bo(3), 64'(8'hC0 + i));
            check("sat_cnt", cnt(3), 64'((i + 1 < CNT_MAX) ? i + 1 : CNT_MAX));
            $display("[TB] ch3 capture data=%02h cnt=%0d", busout[31:24], upd_cnt[7:6]);
            step(1);
        end
        check("sat_pulses", 64'(pulses), 64'd5);
        set_bus(3, 8'hEE);
        req_toggle[3] = ~req_toggle[3];
        step(2);
        clr_cnt[3] = 1'b1;
        step(1);
        check("clr_valid", 64'(busout_valid[3]), 64'h1);
        check("clr_cnt", cnt(3), 64'd0);
        clr_cnt[3] = 1'b0;
        step(1);
        check("clr_cnt_after", cnt(3), 64'd0);

        // Reset while every channel has a request outstanding
        for (int c = 0; c < NUM_CH; c++) set_bus(c, 8'(8'h90 + c));
        req_toggle = ~req_toggle;
        step(2);
        check("mid_pending_all", 64'(pending), 64'hF);
        #2;
        reset      = 1'b0;
        req_toggle = '0;
        #1;
        check("mid_rst_busout",  64'(busout),       64'h0);
        check("mid_rst_ack",     64'(ack_toggle),   64'h0);
        check("mid_rst_valid",   64'(busout_valid), 64'h0);
        check("mid_rst_ready",   64'(ready_out),    64'h0);
        check("mid_rst_pending", 64'(pending),      64'h0);
        check("mid_rst_cnt",     64'(upd_cnt),      64'h0);
        step(2);
        reset = 1'b1;
        step(2);
        check("post_rst_ready", 64'(ready_out), 64'hF);
        check("post_rst_pending", 64'(pending), 64'h0);
        set_bus(0, 8'h5A);
        req_toggle[0] = 1'b1;
        step(2);
        check("post_rst_early", 64'(busout_valid[0]), 64'h0);
        step(1);
        check("post_rst_data", bo(0), 64'h5A);
        check("post_rst_valid", 64'(busout_valid[0]), 64'h1);
        check("post_rst_cnt", cnt(0), 64'd1);
        $display("[TB] ch0 capture data=%02h after reset", busout[7:0]);

        // Random concurrent traffic with random hold
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_m[c] = 0;
            sent[c]  = 0;
            got[c]   = 0;
        end
        cnt_m[0] = 1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            step(1);
            for (int c = 0; c < NUM_CH; c++) begin
                if (busout_valid[c]) begin
                    check("rnd_expected", 64'(exp_q[c].size() != 0), 64'h1);
                    if (exp_q[c].size() != 0) begin
                        d = exp_q[c].pop_front();
                        cnt_m[c] = (cnt_m[c] < CNT_MAX) ? cnt_m[c] + 1 : CNT_MAX;
                        check("rnd_data", bo(c), 64'(d));
                        check("rnd_cnt", cnt(c), 64'(cnt_m[c]));
                        got[c]++;
                        $display("[TB] rnd ch%0d capture data=%02h cnt=%0d", c, d, cnt_m[c]);
                    end
                end
            end
            if (cyc < 900) begin
                hold = NUM_CH'($urandom) & NUM_CH'($urandom);
                for (int c = 0; c < NUM_CH; c++) begin
                    if (req_toggle[c] == ack_toggle[c] && sent[c] < RND_PER_CH &&
                        $urandom_range(0, 2) == 0) begin
                        d = WIDTH'($urandom);
                        set_bus(c, d);
                        req_toggle[c] = ~req_toggle[c];
                        exp_q[c].push_back(d);
                        sent[c]++;
                    end
                end
            end else begin
                hold = '0;
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            check("rnd_none_lost", 64'(exp_q[c].size()), 64'd0);
            check("rnd_count", 64'(got[c]), 64'(RND_PER_CH));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
